// File: rtl/eth_sd_pkg.sv
// rtl/eth_sd_pkg.sv - shared state encoding and defaults for the SD FIFO read path
package eth_sd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } eth_sd_state_t;

    // One 512-byte SD sector at 32 bits per word
    localparam int C_DEFAULT_BURST_LEN = 128;

endpackage

// File: rtl/eth_sd_rd_skid_fifo.sv
// rtl/eth_sd_rd_skid_fifo.sv - small skid FIFO absorbing FIFO read latency
module eth_sd_rd_skid_fifo #(
    parameter int c_WIDTH = 32,
    parameter int c_DEPTH = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push,
    input  logic [c_WIDTH-1:0]             push_data,
    input  logic                           pop,
    output logic [c_WIDTH-1:0]             pop_data,
    output logic [$clog2(c_DEPTH+1)-1:0]   count,
    output logic                           full,
    output logic                           empty
);

    localparam int c_CNT_W = $clog2(c_DEPTH + 1);
    localparam int c_PTR_W = (c_DEPTH > 1) ? $clog2(c_DEPTH) : 1;
    localparam logic [c_PTR_W-1:0] c_LAST_PTR = c_PTR_W'(c_DEPTH - 1);
    localparam logic [c_CNT_W-1:0] c_FULL_CNT = c_CNT_W'(c_DEPTH);

    logic [c_WIDTH-1:0] r_mem [c_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign empty     = (r_count == '0);
    assign full      = (r_count == c_FULL_CNT);
    assign count     = r_count;
    assign pop_data  = r_mem[r_rd_ptr];
    assign w_do_pop  = pop && !empty;
    // A push into a full buffer is fine when the head leaves in the same cycle
    assign w_do_push = push && (!full || w_do_pop);

    function automatic logic [c_PTR_W-1:0] next_ptr(input logic [c_PTR_W-1:0] p);
        return (p == c_LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // Storage, pointers and occupancy; push+pop together leaves count unchanged
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= next_ptr(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= next_ptr(r_rd_ptr);
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_do_push && w_do_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/eth_sd_fifo_rd_ctrl.sv
// rtl/eth_sd_fifo_rd_ctrl.sv - burst reader turning FIFO contents into a framed stream
module eth_sd_fifo_rd_ctrl
    import eth_sd_pkg::*;
#(
    parameter int c_RD_DATA_WIDTH  = 32,
    parameter int c_RD_DEPTH_WIDTH = 10,
    parameter int c_BURST_LEN      = C_DEFAULT_BURST_LEN,
    parameter int c_RD_LATENCY     = 1
) (
    input  logic                          rd_clk,
    input  logic                          rd_rst,
    input  logic                          enable,
    output logic                          fifo_rd_en,
    input  logic [c_RD_DATA_WIDTH-1:0]    fifo_rd_data,
    input  logic                          fifo_rd_empty,
    input  logic [c_RD_DEPTH_WIDTH:0]     fifo_rd_water_level,
    output logic [c_RD_DATA_WIDTH-1:0]    m_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic                          m_sof,
    output logic                          m_eof,
    output logic                          busy,
    output logic                          burst_done,
    output logic [15:0]                   burst_cnt
);

    localparam int c_CNT_W      = c_RD_DEPTH_WIDTH + 1;
    localparam int c_SKID_DEPTH = c_RD_LATENCY + 1;
    localparam int c_SKID_CNT_W = $clog2(c_SKID_DEPTH + 1);
    localparam int c_OUT_W      = c_SKID_CNT_W + 2;

    localparam logic [c_CNT_W-1:0] c_BURST = c_CNT_W'(c_BURST_LEN);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(c_BURST_LEN - 1);
    localparam logic [c_OUT_W-1:0] c_CREDS = c_OUT_W'(c_SKID_DEPTH);

    eth_sd_state_t             r_state;
    logic [c_CNT_W-1:0]        r_issued;
    logic [c_CNT_W-1:0]        r_acc_idx;
    logic [15:0]               r_burst_cnt;
    logic [c_RD_LATENCY-1:0]   r_vld_pipe;

    logic                       w_rd_en;
    logic                       w_push;
    logic                       w_pop;
    logic                       w_last_word;
    logic                       w_done;
    logic [c_RD_DATA_WIDTH-1:0] w_skid_data;
    logic [c_SKID_CNT_W-1:0]    w_skid_count;
    logic                       w_skid_full;
    logic                       w_skid_empty;
    logic [c_OUT_W-1:0]         w_inflight;
    logic [c_OUT_W-1:0]         w_skid_net;

    eth_sd_rd_skid_fifo #(
        .c_WIDTH (c_RD_DATA_WIDTH),
        .c_DEPTH (c_SKID_DEPTH)
    ) u_skid (
        .clk       (rd_clk),
        .rst       (rd_rst),
        .push      (w_push),
        .push_data (fifo_rd_data),
        .pop       (w_pop),
        .pop_data  (w_skid_data),
        .count     (w_skid_count),
        .full      (w_skid_full),
        .empty     (w_skid_empty)
    );

    assign w_push      = r_vld_pipe[c_RD_LATENCY-1];
    assign m_valid     = !w_skid_empty;
    assign m_data      = w_skid_data;
    assign w_pop       = m_valid && m_ready;
    assign w_last_word = (r_acc_idx == c_LAST);
    assign m_sof       = m_valid && (r_acc_idx == '0);
    assign m_eof       = m_valid && w_last_word;
    assign w_done      = (r_state == ST_DRAIN) && w_pop && w_last_word;
    assign burst_done  = w_done;
    assign busy        = (r_state != ST_IDLE);
    assign burst_cnt   = r_burst_cnt;
    assign fifo_rd_en  = w_rd_en;

    // Credit check: words still travelling through the read latency plus what the
    // skid will hold after this cycle's pop must leave room for one more word
    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < c_RD_LATENCY; i++) begin
            w_inflight = w_inflight + c_OUT_W'(r_vld_pipe[i]);
        end
        w_skid_net = c_OUT_W'(w_skid_count) - c_OUT_W'(w_pop);
        w_rd_en    = (r_state == ST_READ) && (r_issued < c_BURST) && !fifo_rd_empty &&
                     ((w_skid_net + w_inflight) < c_CREDS) && !(w_skid_full && !w_pop);
    end

    // Valid pipeline mirroring the FIFO read latency
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            r_vld_pipe <= '0;
        end else begin
            r_vld_pipe[0] <= w_rd_en;
            for (int i = 1; i < c_RD_LATENCY; i++) begin
                r_vld_pipe[i] <= r_vld_pipe[i-1];
            end
        end
    end

    // Burst FSM with issue, accepted-word and completed-burst counters
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            r_state     <= ST_IDLE;
            r_issued    <= '0;
            r_acc_idx   <= '0;
            r_burst_cnt <= '0;
        end else begin
            if (w_pop) begin
                r_acc_idx <= w_last_word ? '0 : r_acc_idx + 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (enable && (fifo_rd_water_level >= c_BURST)) begin
                        r_state  <= ST_READ;
                        r_issued <= '0;
                    end
                end
                ST_READ: begin
                    if (w_rd_en) begin
                        r_issued <= r_issued + 1'b1;
                        if (r_issued == c_LAST) begin
                            r_state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_done) begin
                        r_state     <= ST_IDLE;
                        r_burst_cnt <= r_burst_cnt + 16'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
